// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
package arb_pkg;

  // Arbiter FSM: either nobody owns the mux, or exactly one requester does.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Default configuration used by the top when not overridden.
  localparam int N_REQ_DEF    = 4;
  localparam int DATA_W_DEF   = 1;
  localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// modulo N_REQ, skipping any bit set in excl, and reports the first hit.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  localparam int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [SEL_W-1:0] winner
);

  logic [N_REQ-1:0] masked;
  logic [SEL_W:0]   sum_w [N_REQ];
  logic [SEL_W-1:0] cand  [N_REQ];

  assign masked = req & ~excl;

  // cand[k] is the requester index examined k-th: (ptr + k) mod N_REQ.
  // One extra bit of headroom keeps the sum exact before wrapping.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign sum_w[gi] = {1'b0, ptr} + (SEL_W+1)'(gi);
    assign cand[gi]  = (sum_w[gi] >= (SEL_W+1)'(N_REQ))
                     ? SEL_W'(sum_w[gi] - (SEL_W+1)'(N_REQ))
                     : SEL_W'(sum_w[gi]);
  end

  // Scan from the farthest candidate back to ptr so the nearest hit wins last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (masked[cand[k]]) begin
        found  = 1'b1;
        winner = cand[k];
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter owning one N_REQ:1 data mux. Grants are registered
// and one-hot; the owner keeps the mux until it drops its request, at which
// point the next requester after it (wrapping) takes over without a bubble.
// Optional build macro ARB_HOLD_LIMIT_EN caps each tenure at MAX_HOLD cycles.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ    = N_REQ_DEF,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int MAX_HOLD = MAX_HOLD_DEF,
  localparam int SEL_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic                    grant_valid,
  output logic [DATA_W-1:0]       data_out
);

  arb_state_t       state_reg;
  logic [N_REQ-1:0] grant_reg;
  logic [SEL_W-1:0] sel_reg;
  logic             grant_valid_reg;
  logic [SEL_W-1:0] ptr_reg;

  logic             owner_req;
  logic             hold_hit;
  logic             release_now;
  logic             regrant;
  logic [SEL_W-1:0] ptr_inc;
  logic [SEL_W-1:0] search_ptr;
  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] excl_mask;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;

  assign owner_req  = req[sel_reg];
  assign owner_mask = {{(N_REQ-1){1'b0}}, 1'b1} << sel_reg;
  assign ptr_inc    = (sel_reg == SEL_W'(N_REQ - 1)) ? '0 : sel_reg + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_reg;
  assign hold_hit = (hold_reg == HOLD_W'(MAX_HOLD));
`else
  assign hold_hit = 1'b0;
`endif

  // The owner gives up the mux when it stops requesting or hits its cap.
  assign release_now = (state_reg == GRANT) && (!owner_req || hold_hit);

  // On release the search restarts just past the owner and ignores it, so
  // the owner can only win again if nobody else is asking.
  assign search_ptr = release_now ? ptr_inc : ptr_reg;
  assign excl_mask  = (state_reg == GRANT) ? owner_mask : '0;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req),
    .ptr    (search_ptr),
    .excl   (excl_mask),
    .found  (pick_found),
    .winner (pick_idx)
  );

  assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

  // Capped owner with no competition keeps the mux and starts a new tenure.
  assign regrant = release_now && !pick_found && hold_hit && owner_req;

  // Arbiter FSM with registered grant, select, valid and priority pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      sel_reg         <= '0;
      grant_valid_reg <= 1'b0;
      ptr_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg       <= GRANT;
            grant_reg       <= pick_onehot;
            sel_reg         <= pick_idx;
            grant_valid_reg <= 1'b1;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_reg <= ptr_inc;
            if (pick_found) begin
              grant_reg <= pick_onehot;
              sel_reg   <= pick_idx;
            end else if (!regrant) begin
              // sel keeps the last owner so the mux input stays stable.
              state_reg       <= IDLE;
              grant_reg       <= '0;
              grant_valid_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg       <= IDLE;
          grant_reg       <= '0;
          grant_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  // Tenure counter: 1 on the cycle a grant first appears, +1 per held cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg <= '0;
    end else if (state_reg == IDLE) begin
      hold_reg <= pick_found ? HOLD_W'(1) : '0;
    end else if (release_now) begin
      hold_reg <= (pick_found || regrant) ? HOLD_W'(1) : '0;
    end else begin
      hold_reg <= hold_reg + 1'b1;
    end
  end
`endif

  // Split the packed data bus into per-requester words for the output mux.
  logic [DATA_W-1:0] data_slice [N_REQ];
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign data_slice[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  assign data_out    = grant_valid_reg ? data_slice[sel_reg] : '0;
  assign grant       = grant_reg;
  assign sel         = sel_reg;
  assign grant_valid = grant_valid_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N_REQ=4, DATA_W=4, MAX_HOLD=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  grant;
  logic [1:0]    sel;
  logic          grant_valid;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;

  rr_mux_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .MAX_HOLD (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .data_in     (data_in),
    .grant       (grant),
    .sel         (sel),
    .grant_valid (grant_valid),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all four outputs at once; one line per transaction.
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic gv, input logic [3:0] d);
    $display("t=%0t %s req=%b grant=%b sel=%0d gv=%0b dout=%h", $time, tag, req,
             grant, sel, grant_valid, data_out);
    chk({tag, ".grant"}, 16'(grant), 16'(g));
    chk({tag, ".sel"},   16'(sel),   16'(s));
    chk({tag, ".gv"},    16'(grant_valid), 16'(gv));
    chk({tag, ".dout"},  16'(data_out), 16'(d));
  endtask

  initial begin
    // Slices: req0=5, req1=A, req2=9, req3=D
    data_in = 16'hD9A5;
    req     = '0;
    reset_n = 1'b0;
    #1;
    tick();
    tick();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 4'h0);
    reset_n = 1'b1;

    // Single requester 2: one-cycle latency, data follows slice 2.
    req = 4'b0100;
    tick();
    chk_all("single_r2", 4'b0100, 2'd2, 1'b1, 4'h9);
    data_in = 16'hD3A5;
    #1;
    chk("dout_track", 16'(data_out), 16'h3);
    data_in = 16'hD9A5;
    req = 4'b0000;
    tick();
    chk_all("r2_release_idle", 4'b0000, 2'd2, 1'b0, 4'h0);   // ptr now 3

    // Owner 3 only, drop to idle; sel holds 3, ptr wraps to 0.
    req = 4'b1000;
    tick();
    chk_all("owner3", 4'b1000, 2'd3, 1'b1, 4'hD);
    req = 4'b0000;
    tick();
    chk_all("owner3_idle", 4'b0000, 2'd3, 1'b0, 4'h0);
    req = 4'b0011;
    tick();
    chk_all("wrap_to_0", 4'b0001, 2'd0, 1'b1, 4'h5);

    // All requesting; each owner releases after 2 cycles and re-raises later.
    req = 4'b1111;
    tick();
    chk_all("all_hold0", 4'b0001, 2'd0, 1'b1, 4'h5);
    req = 4'b1110;
    tick();
    chk_all("rot_1", 4'b0010, 2'd1, 1'b1, 4'hA);
    tick();
    chk_all("rot_1_hold", 4'b0010, 2'd1, 1'b1, 4'hA);
    req = 4'b1101;
    tick();
    chk_all("rot_2", 4'b0100, 2'd2, 1'b1, 4'h9);
    tick();
    chk_all("rot_2_hold", 4'b0100, 2'd2, 1'b1, 4'h9);
    req = 4'b1011;
    tick();
    chk_all("rot_3", 4'b1000, 2'd3, 1'b1, 4'hD);
    tick();
    chk_all("rot_3_hold", 4'b1000, 2'd3, 1'b1, 4'hD);
    req = 4'b0111;
    tick();
    chk_all("rot_0", 4'b0001, 2'd0, 1'b1, 4'h5);

    // Owner 1 holds while req[0]/req[2] toggle; release hands to 2.
    req = 4'b0110;
    tick();
    chk_all("own1", 4'b0010, 2'd1, 1'b1, 4'hA);
    req = 4'b0011;
    tick();
    chk_all("own1_nopre_a", 4'b0010, 2'd1, 1'b1, 4'hA);
    req = 4'b0111;
    tick();
    chk_all("own1_nopre_b", 4'b0010, 2'd1, 1'b1, 4'hA);
    req = 4'b0010;
    tick();
    chk_all("own1_nopre_c", 4'b0010, 2'd1, 1'b1, 4'hA);
    req = 4'b0101;
    tick();
    chk_all("own1_to_2", 4'b0100, 2'd2, 1'b1, 4'h9);          // ptr now 2

    // Async reset between edges clears outputs immediately.
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 4'h0);
    req = 4'b1001;
    tick();
    reset_n = 1'b1;
    tick();
    chk_all("post_rst_ptr0", 4'b0001, 2'd0, 1'b1, 4'h5);
    req = 4'b1000;
    tick();
    chk_all("post_rst_r3", 4'b1000, 2'd3, 1'b1, 4'hD);
    req = 4'b0000;
    tick();
    chk_all("final_idle", 4'b0000, 2'd3, 1'b0, 4'h0);

`ifdef ARB_HOLD_LIMIT_EN
    // Hold cap: 0 and 1 alternate every 8 cycles; lone requester is re-granted.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    req = 4'b0011;
    tick();
    for (int k = 0; k < 8; k++) begin
      chk_all("cap_own0", 4'b0001, 2'd0, 1'b1, 4'h5);
      tick();
    end
    for (int k = 0; k < 8; k++) begin
      chk_all("cap_own1", 4'b0010, 2'd1, 1'b1, 4'hA);
      tick();
    end
    chk_all("cap_back0", 4'b0001, 2'd0, 1'b1, 4'h5);
    req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_all("cap_regrant0", 4'b0001, 2'd0, 1'b1, 4'h5);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
